// File: rtl/vga_sram_prefetch.sv
// vga_sram_prefetch: fetches a frame buffer word-by-word from the SRAM bypass
// port into a small FIFO that feeds the pixel pipeline. One read in flight
// at a time; frame_start flushes the FIFO and restarts at fb_base. A read that
// is pending when frame_start arrives is completed and its data is dropped.
// Optional feature macro: VGA_PREFETCH_UNDERRUN_EN adds a sticky underrun flag
// and a saturating underrun event counter.
module vga_sram_prefetch #(
  parameter int DEPTH       = 8,
  parameter int FRAME_WORDS = 76800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] fb_base,
  input  logic        frame_start,
  input  logic        pix_pop,
  output logic [31:0] pix_data,
  output logic        pix_valid,
  output logic [31:0] mod_vga_sram_addr,
  output logic        mod_vga_sram_read,
  input  logic [31:0] mod_vga_sram_data,
  input  logic        mod_vga_sram_rdy
`ifdef VGA_PREFETCH_UNDERRUN_EN
  ,
  output logic        underrun,
  output logic [15:0] underrun_cnt
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int WW = $clog2(FRAME_WORDS + 1);

  typedef enum logic [1:0] {IDLE, REQ, DISCARD, DONE} state_t;

  state_t          state, state_nxt;
  logic [31:0]     mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr, rd_ptr_nxt;
  logic [CW-1:0]   count, count_nxt;
  logic [31:0]     head_nxt;
  logic [WW-1:0]   words_issued;
  logic [31:0]     next_addr;
  logic            armed;   // set by the first frame_start after reset
  logic            push, pop, fifo_room;

  assign pop       = pix_pop && pix_valid;
  assign fifo_room = (count < CW'(DEPTH)) || pop;
  // Dropped when frame_start coincides: that word belongs to the old frame.
  assign push      = (state == REQ) && mod_vga_sram_rdy && !frame_start && fifo_room;
  assign pix_valid = (count != '0);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (frame_start)                                      state_nxt = IDLE;
        else if (armed && words_issued == WW'(FRAME_WORDS))   state_nxt = DONE;
        else if (armed && count < CW'(DEPTH))                 state_nxt = REQ;
      end
      REQ: begin
        if (frame_start)           state_nxt = mod_vga_sram_rdy ? IDLE : DISCARD;
        else if (mod_vga_sram_rdy) state_nxt = IDLE;
      end
      DISCARD: if (mod_vga_sram_rdy) state_nxt = IDLE;
      DONE:    if (frame_start)      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: read is a level for the whole life of a request
  always_comb begin
    mod_vga_sram_read = (state == REQ) || (state == DISCARD);
  end

  // Fetch address / frame progress; request address latched at issue so it
  // stays stable even if frame_start reloads next_addr mid-request
  always_ff @(posedge clk) begin
    if (rst) begin
      next_addr         <= '0;
      mod_vga_sram_addr <= '0;
      words_issued      <= '0;
      armed             <= 1'b0;
    end else begin
      if (state == IDLE && state_nxt == REQ) mod_vga_sram_addr <= next_addr;
      if (frame_start) begin
        next_addr    <= fb_base;
        words_issued <= '0;
        armed        <= 1'b1;
      end else if (state == REQ && mod_vga_sram_rdy) begin
        next_addr    <= next_addr + 32'd4;
        words_issued <= words_issued + 1'b1;
      end
    end
  end

  // FIFO next pointers/count and the word that will be at the head next cycle
  always_comb begin
    rd_ptr_nxt = pop ? rd_ptr + 1'b1 : rd_ptr;
    count_nxt  = count;
    if (push && !pop)      count_nxt = count + 1'b1;
    else if (pop && !push) count_nxt = count - 1'b1;
    // A push landing in the slot that becomes head must be forwarded into
    // the head register, since mem is only written at this edge.
    head_nxt = (push && wr_ptr == rd_ptr_nxt) ? mod_vga_sram_data : mem[rd_ptr_nxt];
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= mod_vga_sram_data;
  end

  // FIFO pointers, occupancy and registered head word
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      pix_data <= '0;
    end else if (frame_start) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      rd_ptr   <= rd_ptr_nxt;
      count    <= count_nxt;
      pix_data <= head_nxt;
    end
  end

`ifdef VGA_PREFETCH_UNDERRUN_EN
  // Sticky underrun flag and saturating event counter
  always_ff @(posedge clk) begin
    if (rst || frame_start) begin
      underrun     <= 1'b0;
      underrun_cnt <= '0;
    end else if (pix_pop && !pix_valid) begin
      underrun <= 1'b1;
      if (underrun_cnt != 16'hFFFF) underrun_cnt <= underrun_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vga_sram_prefetch.sv
// Bench for vga_sram_prefetch: SRAM responder with fixed 3-cycle latency
// returning ~addr as data, a queue-based reference model of the frame fetch,
// a per-cycle compare process, and directed scenarios with literal checks.
module tb_vga_sram_prefetch;
  localparam int DEPTH = 8;
  localparam int FW    = 12;
  localparam int LAT   = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] fb_base = '0;
  logic        frame_start = 1'b0;
  logic        pix_pop = 1'b0;
  logic [31:0] pix_data, addr;
  logic        pix_valid, read;
  logic [31:0] sdata = '0;
  logic        rdy = 1'b0;
`ifdef VGA_PREFETCH_UNDERRUN_EN
  logic        underrun;
  logic [15:0] underrun_cnt;
`endif

  always #5 clk = ~clk;

  vga_sram_prefetch #(.DEPTH(DEPTH), .FRAME_WORDS(FW)) u_dut (
    .clk(clk), .rst(rst), .fb_base(fb_base), .frame_start(frame_start),
    .pix_pop(pix_pop), .pix_data(pix_data), .pix_valid(pix_valid),
    .mod_vga_sram_addr(addr), .mod_vga_sram_read(read),
    .mod_vga_sram_data(sdata), .mod_vga_sram_rdy(rdy)
`ifdef VGA_PREFETCH_UNDERRUN_EN
    , .underrun(underrun), .underrun_cnt(underrun_cnt)
`endif
  );

  int total = 0;
  int passed = 0;

  // reference model state
  logic [31:0] q[$];
  bit          armed = 0, pending = 0, disc = 0, just_done = 0, chk_en = 0;
  int          words = 0;
  int          req_cnt = 0;
  logic [31:0] exp_addr = '0, held_addr = '0, last_addr = '0;
  logic        s_read = 1'b0;
  bit          force_rdy = 0;
  int          rsp_cnt = 0;

  task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (ok) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // SRAM: strobe rdy on the LAT-th cycle a read is seen, data = ~addr
  always @(negedge clk) begin : sram
    rdy   = 1'b0;
    sdata = 32'hBAD0BAD0;
    if (force_rdy) begin
      rdy   = 1'b1;
      sdata = 32'h5555AAAA;
    end else if (read) begin
      rsp_cnt++;
      if (rsp_cnt == LAT) begin
        rdy     = 1'b1;
        sdata   = ~addr;
        rsp_cnt = 0;
      end
    end else begin
      rsp_cnt = 0;
    end
  end

  // Model: FIFO contents and fetch progress advance on each clock edge
  always @(posedge clk) begin : model
    bit mpop, done_now;
    if (rst) begin
      q.delete();
      armed = 0; pending = 0; disc = 0; just_done = 0;
      words = 0; exp_addr = '0; chk_en = 1;
    end else begin
      mpop     = pix_pop && (q.size() != 0);
      done_now = s_read && rdy;
      if (mpop) void'(q.pop_front());
      if (done_now) begin
        if (!disc && !frame_start) begin
          q.push_back(~held_addr);
          exp_addr = exp_addr + 32'd4;
          words++;
        end
        pending = 0; disc = 0; just_done = 1;
      end
      if (frame_start) begin
        q.delete();
        exp_addr = fb_base;
        words    = 0;
        armed    = 1;
        if (pending) disc = 1;
      end
    end
  end

  // Compare DUT outputs against the model every cycle
  always @(negedge clk) begin : cmp
    s_read = read;
    if (chk_en) begin
      chk(pix_valid == (q.size() != 0), "pix_valid", 32'(pix_valid), 32'(q.size() != 0));
      if (pix_valid && q.size() != 0) chk(pix_data == q[0], "pix_data", pix_data, q[0]);
      if (just_done) begin
        chk(!read, "read_gap", 32'(read), 32'd0);
        just_done = 0;
      end else if (pending) begin
        chk(read && addr == held_addr, "req_hold", addr, held_addr);
      end else if (read) begin
        chk(armed && words < FW && q.size() < DEPTH, "req_allowed", 32'(q.size()), 32'(words));
        chk(addr == exp_addr, "req_addr", addr, exp_addr);
        pending   = 1;
        held_addr = addr;
        last_addr = addr;
        req_cnt++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_req(input int n, input int budget);
    int i = 0;
    while (req_cnt < n && i < budget) begin tick(); i++; end
    chk(req_cnt >= n, "wait_req", 32'(req_cnt), 32'(n));
  endtask

  initial begin
    int i, base;
    // reset state
    rst = 1'b1; tick(); tick();
    chk(!pix_valid, "rst_valid", 32'(pix_valid), 32'd0);
    chk(pix_data == 32'd0, "rst_data", pix_data, 32'd0);
    chk(!read, "rst_read", 32'(read), 32'd0);
    chk(addr == 32'd0, "rst_addr", addr, 32'd0);
    rst = 1'b0;
    repeat (6) tick();
    chk(!read, "no_fetch_before_start", 32'(read), 32'd0);

    // fill: 8 reads from 0x10000, then stall on full FIFO
    fb_base = 32'h0001_0000; frame_start = 1'b1; tick(); frame_start = 1'b0;
    wait_req(8, 100);
    repeat (20) tick();
    chk(req_cnt == 8, "fill_reads", 32'(req_cnt), 32'd8);
    chk(!read, "full_no_read", 32'(read), 32'd0);
    chk(pix_valid, "full_valid", 32'(pix_valid), 32'd1);
    chk(pix_data == 32'hFFFE_FFFF, "full_head", pix_data, 32'hFFFE_FFFF);
    chk(last_addr == 32'h0001_001C, "fill_last_addr", last_addr, 32'h0001_001C);

    // single pop advances head; then drain to end of frame (DONE)
    pix_pop = 1'b1; tick(); pix_pop = 1'b0;
    chk(pix_data == 32'hFFFE_FFFB, "pop_advance", pix_data, 32'hFFFE_FFFB);
    pix_pop = 1'b1;
    wait_req(FW, 200);
    repeat (30) tick();
    pix_pop = 1'b0;
    repeat (20) tick();
    chk(req_cnt == FW, "done_reads", 32'(req_cnt), 32'(FW));
    chk(!read, "done_no_read", 32'(read), 32'd0);
    chk(!pix_valid, "done_drained", 32'(pix_valid), 32'd0);

    // frame_start with read pending at 0x10008, then again during DISCARD
    fb_base = 32'h0001_0000; frame_start = 1'b1; tick(); frame_start = 1'b0;
    i = 0;
    while (!(read && addr == 32'h0001_0008) && i < 100) begin tick(); i++; end
    chk(read && addr == 32'h0001_0008, "pend_10008", addr, 32'h0001_0008);
    fb_base = 32'h0001_8000; frame_start = 1'b1; tick();
    chk(!pix_valid, "flush_valid", 32'(pix_valid), 32'd0);
    fb_base = 32'h0002_0000; tick(); frame_start = 1'b0;
    chk(read && addr == 32'h0001_0008, "discard_hold", addr, 32'h0001_0008);
    base = req_cnt;
    wait_req(base + 1, 50);
    chk(last_addr == 32'h0002_0000, "post_discard_addr", last_addr, 32'h0002_0000);

    // reset mid-request, stray rdy while idle, no fetch until frame_start
    i = 0;
    while (!read && i < 50) begin tick(); i++; end
    chk(read, "pending_before_rst", 32'(read), 32'd1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk(!read, "rst_drop_read", 32'(read), 32'd0);
    chk(addr == 32'd0, "rst_drop_addr", addr, 32'd0);
    force_rdy = 1; tick(); force_rdy = 0; tick();
    chk(!pix_valid, "stray_rdy_ignored", 32'(pix_valid), 32'd0);
    repeat (10) tick();
    chk(!read, "no_fetch_after_rst", 32'(read), 32'd0);

    // address wrap modulo 2^32
    fb_base = 32'hFFFF_FFF8; frame_start = 1'b1; tick(); frame_start = 1'b0;
    pix_pop = 1'b1;
    base = req_cnt;
    wait_req(base + 3, 100);
    chk(last_addr == 32'h0000_0000, "wrap_zero", last_addr, 32'h0000_0000);
    wait_req(base + 4, 50);
    chk(last_addr == 32'h0000_0004, "wrap_four", last_addr, 32'h0000_0004);
    pix_pop = 1'b0;

`ifdef VGA_PREFETCH_UNDERRUN_EN
    // three pops on an empty FIFO
    rst = 1'b1; tick(); rst = 1'b0;
    pix_pop = 1'b1; repeat (3) tick(); pix_pop = 1'b0;
    chk(underrun == 1'b1, "underrun_set", 32'(underrun), 32'd1);
    chk(underrun_cnt == 16'd3, "underrun_cnt", 32'(underrun_cnt), 32'd3);
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    chk(underrun == 1'b0, "underrun_clr", 32'(underrun), 32'd0);
    chk(underrun_cnt == 16'd0, "underrun_cnt_clr", 32'(underrun_cnt), 32'd0);
`endif

    repeat (5) tick();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/vga_sram_prefetch.md
VGA_SRAM_PREFETCH -- requirements
Module: vga_sram_prefetch

Interface
REQ-001 SHALL have parameter DEPTH, default 8, FIFO depth in 32-bit words (power of two, 2..64).
REQ-002 SHALL have parameter FRAME_WORDS, default 76800, words fetched per frame (640x480, 8bpp).
REQ-003 SHALL have port clk  input  1  system clock; all logic on posedge clk; one clock only.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port fb_base  input  32  frame buffer byte address (word-aligned), sampled at frame_start.
REQ-006 SHALL have port frame_start  input  1  one-cycle pulse that restarts fetching at fb_base.
REQ-007 SHALL have port pix_pop  input  1  pixel side consumes pix_data this cycle.
REQ-008 SHALL have port pix_data  output  32  FIFO head word.
REQ-009 SHALL have port pix_valid  output  1  FIFO not empty.
REQ-010 SHALL have port mod_vga_sram_addr  output  32  read byte address to the SRAM bypass port.
REQ-011 SHALL have port mod_vga_sram_read  output  1  read request, level.
REQ-012 SHALL have port mod_vga_sram_data  input  32  read data, valid when mod_vga_sram_rdy=1.
REQ-013 SHALL have port mod_vga_sram_rdy  input  1  one-cycle read-complete strobe.

Function
REQ-014 SHALL implement FSM states IDLE, REQ, DISCARD, DONE.
REQ-015 IDLE->REQ when (count + 0) < DEPTH and words_issued < FRAME_WORDS; IDLE->DONE when words_issued == FRAME_WORDS.
REQ-016 In REQ, mod_vga_sram_read=1 and mod_vga_sram_addr SHALL hold constant until mod_vga_sram_rdy=1 is sampled.
REQ-017 On rdy in REQ: push mod_vga_sram_data, addr += 4, words_issued += 1, go IDLE; read SHALL be 0 for at least one cycle between requests.
REQ-018 At most one request in flight; no request issued when FIFO full (count == DEPTH).
REQ-019 pix_pop with pix_valid=1 SHALL advance the head next cycle; pix_pop with pix_valid=0 SHALL be ignored.
REQ-020 Simultaneous push and pop SHALL leave count unchanged, including at count == DEPTH (pop frees the slot, push accepted) and count == 0 (no push bypass: pix_valid rises the cycle after the push).
REQ-021 pix_data SHALL be registered FIFO output; push-to-pix_valid latency one cycle.
REQ-022 frame_start SHALL flush FIFO (count=0, pix_valid=0 next cycle), load addr=fb_base, words_issued=0.
REQ-023 frame_start while in REQ SHALL go DISCARD: read held until rdy, returned word dropped, then IDLE; no new request before the pending one completes.
REQ-024 frame_start during DISCARD SHALL reload fb_base and remain in DISCARD.
REQ-025 DONE SHALL issue no reads; FIFO drains normally; exit only via frame_start.
REQ-026 Address arithmetic 32-bit, wraps modulo 2^32 without error.

Reset
REQ-027 rst SHALL force state=IDLE, count=0, pix_valid=0, pix_data=0, mod_vga_sram_read=0, mod_vga_sram_addr=0, words_issued=0 on the next posedge.
REQ-028 rst mid-request SHALL drop read immediately; a later rdy strobe SHALL be ignored while IDLE.
REQ-029 After rst, no fetch SHALL start until the first frame_start.

Configuration
REQ-030 With VGA_PREFETCH_UNDERRUN_EN defined: output underrun (1 bit, sticky) sets when pix_pop=1 and pix_valid=0; cleared by rst or frame_start; output underrun_cnt (16 bits, saturating) counts such events, cleared likewise.
REQ-031 Without VGA_PREFETCH_UNDERRUN_EN: neither port exists, no counter logic.

Verification
REQ-032 rst, frame_start with fb_base=0x00010000, rdy 3 cycles after each read, no pops -> 8 reads at 0x10000..0x1001C, then read stays 0, pix_valid=1, count=8.
REQ-033 FIFO full, then pix_pop each cycle -> next read issued after first pop, data order matches address order.
REQ-034 frame_start while read pending at 0x10008 -> read held until rdy, word discarded, next read at fb_base, pix_valid=0 the cycle after frame_start.
REQ-035 FRAME_WORDS=4 -> exactly 4 reads, state DONE, no further read until frame_start.
REQ-036 count=8 with push and pop same cycle -> count stays 8, no word lost.
REQ-037 VGA_PREFETCH_UNDERRUN_EN defined, 3 pops on empty FIFO -> underrun=1, underrun_cnt=3; frame_start -> both 0.
